// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter and sequencer sharing one 4-bit ALU between two requesters
module alu_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_A,
  input  logic [3:0] req0_B,
  input  logic [1:0] req0_ALUControl,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_A,
  input  logic [3:0] req1_B,
  input  logic [1:0] req1_ALUControl,
  output logic       rsp0_valid,
  input  logic       rsp0_ready,
  output logic       rsp1_valid,
  input  logic       rsp1_ready,
  output logic [3:0] rsp_Result,
  output logic [3:0] rsp_ALUFlags,
  output logic [3:0] alu_A,
  output logic [3:0] alu_B,
  output logic [1:0] alu_ALUControl,
  input  logic [3:0] alu_Result,
  input  logic [3:0] alu_ALUFlags,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic       last;
  logic       grant;
  logic       sel;
  logic       sel_valid;
  logic [3:0] count;

  // On contention the requester that was not served last wins.
  always_comb begin
    sel_valid = req0_valid | req1_valid;
    sel       = 1'b0;
    if (req0_valid && req1_valid)
      sel = ~last;
    else if (req1_valid)
      sel = 1'b1;
  end

  assign req0_ready = !reset && (state == IDLE) && sel_valid && !sel;
  assign req1_ready = !reset && (state == IDLE) && sel_valid && sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last           <= 1'b1;
      grant          <= 1'b0;
      count          <= 4'd0;
      alu_A          <= 4'd0;
      alu_B          <= 4'd0;
      alu_ALUControl <= 2'd0;
      rsp_Result     <= 4'd0;
      rsp_ALUFlags   <= 4'd0;
      rsp0_valid     <= 1'b0;
      rsp1_valid     <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            alu_A          <= sel ? req1_A : req0_A;
            alu_B          <= sel ? req1_B : req0_B;
            alu_ALUControl <= sel ? req1_ALUControl : req0_ALUControl;
            grant          <= sel;
            count          <= LOAD;
            busy           <= 1'b1;
            state          <= EXEC;
          end
        end
        EXEC: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            rsp_Result   <= alu_Result;
            rsp_ALUFlags <= alu_ALUFlags;
            rsp0_valid   <= !grant;
            rsp1_valid   <= grant;
            state        <= RESP;
          end
        end
        RESP: begin
          if (grant ? rsp1_ready : rsp0_ready) begin
            last       <= grant;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer for the shared 4-bit ALU datapath (ops: add, sub, AND, OR; flags N/Z/C/V). It accepts operations from two independent requesters over valid/ready handshakes and grants the single ALU round-robin. It holds registered operands on the ALU for a programmable settle window, captures Result and ALUFlags, and returns them to the granted requester over a response handshake. It sits between the execution-side clients and the combinational ALU instance.

## Interface
- EXEC_CYCLES, 1: cycles operands are held on the ALU before capture; legal range 1–15.
- clk in 1: single clock; all state changes on the rising edge.
- reset in 1: synchronous, active-high.
- req0_valid in 1 / req0_ready out 1: requester 0 operation handshake.
- req0_A, req0_B in 4 each: requester 0 operands.
- req0_ALUControl in 2: requester 0 op; 00 add, 01 sub, 10 AND, 11 OR.
- req1_valid, req1_ready, req1_A, req1_B, req1_ALUControl: same for requester 1.
- rsp0_valid out 1 / rsp0_ready in 1: requester 0 response handshake.
- rsp1_valid out 1 / rsp1_ready in 1: requester 1 response handshake.
- rsp_Result out 4: captured ALU result, shared by both responses.
- rsp_ALUFlags out 4: captured flags; [0] N, [1] Z, [2] C, [3] V.
- alu_A, alu_B out 4 each; alu_ALUControl out 2: registered drive to the ALU.
- alu_Result in 4, alu_ALUFlags in 4: ALU outputs.
- busy out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, EXEC, RESP. Reset enters IDLE.
- Grant pointer `last`; reset value 1, so requester 0 wins the first contention.
- IDLE arbitration:
  - One valid requester: it is selected.
  - Both valid: the requester other than `last` is selected.
  - reqN_ready is high only for the selected requester, and only in IDLE. It is combinational from valid and `last`.
  - Neither valid: no ready asserted.
- Accept (valid && ready in IDLE):
  - Latch A, B, ALUControl into the alu_* registers and record the grant index.
  - Load the counter with EXEC_CYCLES-1 and go to EXEC.
- EXEC:
  - alu_* stay constant.
  - When the counter is nonzero, decrement it.
  - When the counter is 0, capture alu_Result and alu_ALUFlags into rsp_* and go to RESP.
- RESP:
  - rspG_valid is high for the granted requester only.
  - rsp_Result and rsp_ALUFlags are held stable.
  - When rspG_ready is high, set `last` to G and go to IDLE.
  - rspG_valid stays asserted until the handshake completes; it never drops early.
- alu_* hold their last values in IDLE and RESP.
- rsp_* hold their last captured values until the next capture.
- The response to requester G does not depend on rsp of the other requester.
- The other requester's req_valid is ignored outside IDLE; its request simply waits.
- Reset values: every output 0 (all ready/valid, busy, alu_*, rsp_*). Counter is 0, `last` is 1.
- Reset asserted in any state, mid-operation included: the operation is abandoned and no response is produced. The state is IDLE on the next cycle.

## Timing
- Accept at edge T. EXEC occupies cycles T+1 .. T+EXEC_CYCLES. Capture happens at the edge ending cycle T+EXEC_CYCLES.
- rspG_valid rises in cycle T+EXEC_CYCLES+1.
- With rsp_ready held high, the handshake completes that same cycle and IDLE starts the next cycle. A new accept is possible in that IDLE cycle.
- Minimum issue interval: EXEC_CYCLES+2 cycles.
- busy is registered with state; it is high from T+1 through the response-handshake cycle inclusive.
- With both requesters continuously valid and responses accepted immediately, grants strictly alternate 0,1,0,1…

## Test plan
- Requester 0 only, add A=5, B=3, EXEC_CYCLES=1 -> rsp0_valid 2 cycles after accept, rsp_Result=8, rsp_ALUFlags=4'b1001 (N,V).
- Requester 1, sub A=3, B=3 -> rsp_Result=0, rsp_ALUFlags=4'b0110 (Z,C); rsp0_valid stays 0 throughout.
- Both valid in the same cycle from reset: req0 AND A=4'hA, B=4'h5; req1 OR A=4'hA, B=4'h5.
  - req0 granted first: Result=0, flags 4'b0010.
  - Then req1: Result=4'hF, flags 4'b0001.
  - The next contention is won by req0.
- rsp_ready held low for 5 cycles in RESP -> rsp_valid stays high and rsp_Result stays stable; req_ready stays 0 and busy stays 1. Release -> IDLE next cycle.
- EXEC_CYCLES=4 -> alu_* constant for 4 cycles, with the response in cycle T+5. Alternation under saturated load is verified over 20 operations.
- Reset asserted in EXEC -> next cycle every output is 0. No response is ever issued for the abandoned op. After deassert, the first contention is won by req0.
